// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR sequencing controller and its result FIFO.
package fir_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    FRAME_RUN = 1'b1
  } state_t;

  localparam int NIB_W        = 4;
  localparam int SAMPLE_W     = 8;
  localparam int RES_W        = 16;
  localparam int FIFO_DEPTH   = 2;
  localparam int NIBS_PER_RES = RES_W / NIB_W;

endpackage

// File: rtl/fir_res_fifo.sv
// Small show-ahead result FIFO; a push into a full FIFO without a pop is dropped
// and latches a sticky overrun flag.
module fir_res_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             overrun_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             full, do_pop, do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

  assign data_o    = mem_q[rd_q];
  assign empty_o   = (cnt_q == '0);
  assign overrun_o = ovf_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a nibble-serial systolic FIR chain: coefficient file, sample
// issue FSM, result capture with pipeline-fill skipping, and output FIFO.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int NTAP  = 8,
  parameter int FRAME = 5,
  parameter int SKIP  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NTAP)-1:0] cfg_addr,
  input  logic [7:0]              cfg_data,
  output logic [8*NTAP-1:0]       coef,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_W-1:0]     s_data,
  output logic                    pe_rdy,
  output logic [NIB_W-1:0]        pe_xin,
  output logic [NIB_W-1:0]        pe_yin,
  input  logic                    pe_cap_rdy,
  input  logic [NIB_W-1:0]        pe_yout,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RES_W-1:0]        m_data,
  output logic                    overrun
);

  localparam int ADDR_W    = $clog2(NTAP);
  localparam int SLOT_W    = $clog2(FRAME);
  localparam int NIB_IDX_W = $clog2(NIBS_PER_RES);
  localparam int SKIP_W    = $clog2(SKIP + 2);

  // Addresses with no matching tap simply never hit a write enable.
  for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
    logic [7:0] tap_q;
    always_ff @(posedge clk) begin
      if (rst) tap_q <= '0;
      else if (cfg_we && (cfg_addr == ADDR_W'(gi))) tap_q <= cfg_data;
    end
    assign coef[8*gi +: 8] = rst ? 8'h00 : tap_q;
  end

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                s_ready_c, pe_rdy_c;
  logic [NIB_W-1:0]    pe_xin_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    sample_d  = sample_q;
    s_ready_c = 1'b0;
    pe_rdy_c  = 1'b0;
    pe_xin_c  = '0;
    case (state_q)
      IDLE: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          state_d  = FRAME_RUN;
          slot_d   = '0;
          sample_d = s_data;
        end
      end
      FRAME_RUN: begin
        pe_rdy_c = (slot_q == SLOT_W'(0));
        if (slot_q == SLOT_W'(1)) pe_xin_c = sample_q[NIB_W-1:0];
        if (slot_q == SLOT_W'(2)) pe_xin_c = sample_q[SAMPLE_W-1:NIB_W];
        if (slot_q == SLOT_W'(FRAME - 1)) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready = s_ready_c & ~rst;
  assign pe_rdy  = pe_rdy_c & ~rst;
  assign pe_xin  = rst ? '0 : pe_xin_c;
  assign pe_yin  = '0;

  logic                 cap_active_q;
  logic [NIB_IDX_W-1:0] nib_q;
  logic [RES_W-1:0]     word_q;
  logic                 done_q;
  logic [SKIP_W-1:0]    skip_q;

  // Nibbles arrive LSB first, so shifting in from the top leaves them in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_active_q <= 1'b0;
      nib_q        <= '0;
      word_q       <= '0;
      done_q       <= 1'b0;
      skip_q       <= SKIP_W'(SKIP);
    end else begin
      done_q <= 1'b0;
      if (cap_active_q) begin
        word_q <= {pe_yout, word_q[RES_W-1:NIB_W]};
        if (nib_q == NIB_IDX_W'(NIBS_PER_RES - 1)) begin
          cap_active_q <= 1'b0;
          nib_q        <= '0;
          if (skip_q != '0) skip_q <= skip_q - 1'b1;
          else              done_q <= 1'b1;
        end else begin
          nib_q <= nib_q + 1'b1;
        end
      end else if (pe_cap_rdy) begin
        cap_active_q <= 1'b1;
        nib_q        <= '0;
      end
    end
  end

  logic fifo_empty, fifo_ovf, pop;

  assign m_valid = ~fifo_empty & ~rst;
  assign pop     = m_valid & m_ready;
  assign overrun = fifo_ovf & ~rst;

  fir_res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (done_q),
    .data_i    (word_q),
    .pop_i     (pop),
    .data_o    (m_data),
    .empty_o   (fifo_empty),
    .overrun_o (fifo_ovf)
  );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: issue-timing model, scoreboard for results,
// and a second narrow instance to exercise out-of-range coefficient addresses.
module tb_fir_seq_ctrl;

  localparam int NTAP  = 8;
  localparam int FRAME = 5;
  localparam int SKIP  = 2;

  logic        clk = 1'b0, rst = 1'b1, cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [63:0] coef;
  logic [47:0] coef6;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_data = '0;
  logic        pe_rdy, pe_cap_rdy = 1'b0;
  logic [3:0]  pe_xin, pe_yin, pe_yout = '0;
  logic        m_valid, m_ready = 1'b0, overrun;
  logic [15:0] m_data;
  logic        s_ready6, pe_rdy6, m_valid6, overrun6;
  logic [3:0]  pe_xin6, pe_yin6;
  logic [15:0] m_data6;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.NTAP(NTAP), .FRAME(FRAME), .SKIP(SKIP)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .coef(coef), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pe_rdy(pe_rdy), .pe_xin(pe_xin), .pe_yin(pe_yin), .pe_cap_rdy(pe_cap_rdy),
    .pe_yout(pe_yout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .overrun(overrun));

  fir_seq_ctrl #(.NTAP(6), .FRAME(FRAME), .SKIP(SKIP)) u_dut6 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .coef(coef6), .s_valid(s_valid), .s_ready(s_ready6), .s_data(s_data),
    .pe_rdy(pe_rdy6), .pe_xin(pe_xin6), .pe_yin(pe_yin6), .pe_cap_rdy(pe_cap_rdy),
    .pe_yout(pe_yout), .m_valid(m_valid6), .m_ready(m_ready), .m_data(m_data6),
    .overrun(overrun6));

  int          checks = 0, errors = 0, cyc = 0, popped = 0, words_done = 0;
  logic [63:0] coef_m8 = '0;
  logic [47:0] coef_m6 = '0;
  logic [15:0] exp_q[$];
  bit          exp_ovf = 1'b0;
  bit          pend_valid = 1'b0;
  int          pend_cyc = 0;
  logic [15:0] pend_word = '0;
  bit          a_valid = 1'b0;
  int          a_cyc = 0;
  logic [7:0]  a_data = '0;
  bit          rand_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Issue timing model: outputs follow from the offset since the last accepted sample.
  initial forever begin
    int  k;
    bit  e_srdy, e_rdy;
    logic [3:0] e_xin;
    @(negedge clk);
    if (rst) begin
      chk("rst_pe_rdy", pe_rdy, 0);
      chk("rst_pe_xin", pe_xin, 0);
      chk("rst_pe_yin", pe_yin, 0);
      a_valid = 1'b0;
    end else begin
      k      = cyc - a_cyc;
      e_srdy = !a_valid || (k > FRAME);
      e_rdy  = a_valid && (k == 1);
      e_xin  = (a_valid && k == 2) ? a_data[3:0] : (a_valid && k == 3) ? a_data[7:4] : 4'h0;
      chk("s_ready", s_ready, e_srdy);
      chk("pe_rdy", pe_rdy, e_rdy);
      chk("pe_xin", pe_xin, e_xin);
      chk("pe_yin", pe_yin, 0);
      if (s_valid && e_srdy) begin
        a_valid = 1'b1;
        a_cyc   = cyc;
        a_data  = s_data;
      end
    end
  end

  // Result scoreboard: exp_q is the reference FIFO content.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_overrun", overrun, 0);
      exp_q.delete();
      exp_ovf    = 1'b0;
      pend_valid = 1'b0;
      words_done = 0;
      coef_m8    = '0;
      coef_m6    = '0;
    end else begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
      chk("overrun", overrun, exp_ovf);
      if (m_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (pend_valid && pend_cyc == cyc) begin
        pend_valid = 1'b0;
        if (exp_q.size() < 2) exp_q.push_back(pend_word);
        else exp_ovf = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step(1);
    cfg_we = 1'b0;
    if (!rst) begin
      coef_m8[8*a +: 8] = d;
      if (a < 3'd6) coef_m6[8*a +: 8] = d;
    end
    chk("coef8", coef, coef_m8);
    chk("coef6", coef6, coef_m6);
  endtask

  task automatic issue(input logic [7:0] d);
    bit acc = 1'b0;
    s_valid = 1'b1; s_data = d;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      step(1);
    end
    s_valid = 1'b0;
    chk("issue_accept", acc, 1);
  endtask

  // Emulates the last PE: pulse, then four result nibbles LSB first.
  task automatic cap_word(input logic [15:0] w, input bit glitch, input int rst_nib,
                          input bit rdy_push);
    pe_cap_rdy = 1'b1;
    step(1);
    pe_cap_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pe_yout = w[4*k +: 4];
      if (glitch && k == 1) pe_cap_rdy = 1'b1;
      if (k == rst_nib) rst = 1'b1;
      step(1);
      pe_cap_rdy = 1'b0;
      if (rst) begin
        rst = 1'b0;
        pe_yout = '0;
        return;
      end
    end
    pe_yout = '0;
    words_done++;
    if (words_done > SKIP) begin
      pend_word  = w;
      pend_cyc   = cyc;
      pend_valid = 1'b1;
    end
    if (rdy_push) m_ready = 1'b1;
  endtask

  initial begin
    int p0;
    step(3);
    chk("rst_coef", coef, 0);
    cfg_write(3'd5, 8'hFF);
    rst = 1'b0;
    cfg_write(3'd3, 8'h5A);
    chk("coef_tap3", coef[31:24], 8'h5A);
    for (int i = 0; i < 12; i++) cfg_write(3'($urandom), 8'($urandom));

    issue(8'hC3);
    step(FRAME + 2);

    m_ready = 1'b1;
    p0 = popped;
    cap_word(16'hBEEF, 1'b0, -1, 1'b0);
    cap_word(16'hDEAD, 1'b1, -1, 1'b0);
    cap_word(16'h1234, 1'b0, -1, 1'b0);
    step(4);
    chk("skip_then_one", popped - p0, 1);

    m_ready = 1'b0;
    cap_word(16'hA1A1, 1'b0, -1, 1'b0);
    cap_word(16'hB2B2, 1'b0, -1, 1'b0);
    cap_word(16'hC3C3, 1'b0, -1, 1'b0);
    step(3);
    chk("overrun_set", overrun, 1);
    p0 = popped;
    m_ready = 1'b1;
    step(4);
    m_ready = 1'b0;
    chk("drain_two", popped - p0, 2);

    fork
      begin
        fork
          for (int i = 0; i < 15; i++) begin
            step($urandom_range(0, 4));
            issue(8'($urandom));
          end
          for (int i = 0; i < 12; i++) begin
            step($urandom_range(0, 3));
            cap_word(16'($urandom), 1'($urandom_range(0, 1)), -1, 1'b0);
          end
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        m_ready = 1'($urandom_range(0, 1));
        step(1);
      end
    join
    m_ready = 1'b1;
    step(6);
    chk("rand_drained", exp_q.size(), 0);

    issue(8'h96);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    cap_word(16'h7777, 1'b0, 3, 1'b0);
    step(6);
    p0 = popped;
    cap_word(16'h1111, 1'b0, -1, 1'b0);
    cap_word(16'h2222, 1'b0, -1, 1'b0);
    step(4);
    chk("skip_reload", popped - p0, 0);

    m_ready = 1'b0;
    p0 = popped;
    cap_word(16'h0A0A, 1'b0, -1, 1'b0);
    cap_word(16'h0B0B, 1'b0, -1, 1'b0);
    cap_word(16'h0C0C, 1'b0, -1, 1'b1);
    step(1);
    m_ready = 1'b0;
    step(2);
    chk("full_pushpop_no_ovf", overrun, 0);
    m_ready = 1'b1;
    step(4);
    chk("full_pushpop_out", popped - p0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
